// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the cache/memory responder
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

  typedef enum logic {RESP_IDLE, RESP_BUSY} resp_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection between icache and dcache (CACHE_ARB_FAIR_EN selects alternation)
module mem_arb_pick
  import cpu_types_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t grant
);

  arb_owner_t tie_pick;

`ifdef CACHE_ARB_FAIR_EN
  // On a tie, hand the port to whichever master did not finish the last burst.
  assign tie_pick = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
  // Strict priority: dcache always wins a tie; last_owner only matters for alternation.
  logic unused_last_owner;
  assign tie_pick          = OWN_D;
  assign unused_last_owner = ^last_owner;
`endif

  // Pick the single master to serve next from the live request lines.
  always_comb begin
    grant = OWN_NONE;
    if (d_req && i_req) begin
      grant = tie_pick;
    end else if (d_req) begin
      grant = OWN_D;
    end else if (i_req) begin
      grant = OWN_I;
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - memory-side responder for icache/dcache word requests (CACHE_ARB_FAIR_EN)
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int BURST_LEN = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output word_t             iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output word_t             dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  logic              ram_ready
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  resp_state_t       state, state_n;
  arb_owner_t        owner, owner_n;
  arb_owner_t        last_owner, last_owner_n;
  arb_owner_t        grant;
  logic [BEAT_W-1:0] beat, beat_n, beat_inc;
  logic              d_req;
  logic              owner_req;

  assign d_req    = dREN | dWEN;
  assign beat_inc = beat + 1'b1;

  mem_arb_pick u_arb (
    .i_req      (iREN),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant      (grant)
  );

  // State register: FSM state, current owner, beat count and last burst owner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RESP_IDLE;
      owner      <= OWN_NONE;
      beat       <= '0;
      last_owner <= OWN_I;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      beat       <= beat_n;
      last_owner <= last_owner_n;
    end
  end

  // Next state plus pass-through of the owner's live request to RAM; reset masks any completion.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    beat_n       = beat;
    last_owner_n = last_owner;
    owner_req    = 1'b0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    if (!RST && state == RESP_BUSY) begin
      case (owner)
        OWN_D: begin
          owner_req = d_req;
          ramWEN    = dWEN;
          ramREN    = dREN & ~dWEN;
          ramaddr   = daddr;
          ramstore  = dstore;
          if (d_req && ram_ready) begin
            dwait = 1'b0;
            if (!dWEN) begin
              dload = ramload;
            end
          end
        end
        OWN_I: begin
          owner_req = iREN;
          ramREN    = iREN;
          ramaddr   = iaddr;
          if (iREN && ram_ready) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
        default: owner_req = 1'b0;
      endcase
    end

    case (state)
      RESP_IDLE: begin
        if (grant != OWN_NONE) begin
          state_n = RESP_BUSY;
          owner_n = grant;
          beat_n  = '0;
        end
      end
      RESP_BUSY: begin
        if (!owner_req) begin
          state_n = RESP_IDLE;
          owner_n = OWN_NONE;
          beat_n  = '0;
        end else if (ram_ready) begin
          if (beat_inc == BEAT_W'(BURST_LEN)) begin
            state_n      = RESP_IDLE;
            owner_n      = OWN_NONE;
            beat_n       = '0;
            last_owner_n = owner;
          end else begin
            beat_n = beat_inc;
          end
        end
      end
      default: begin
        state_n = RESP_IDLE;
        owner_n = OWN_NONE;
        beat_n  = '0;
      end
    endcase
  end

endmodule
